// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies the synchronized lock
// indicator, retries failed attempts, and latches a fault once retries run out.
module pll_lock_ctrl #(
  parameter int RESET_CYCLES  = 10,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16,
  parameter int RTY_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_restart,
  output logic             pll_areset,
  output logic             clk_ready,
  output logic             lock_lost,
  output logic             fault,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             lock_lost_d;
  logic             fail;

  assign locked_s  = sync_q[1];
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

  // soft_restart is a single-cycle strobe; it outranks every state transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    fail        = 1'b0;
    if (soft_restart) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (locked_s)               state_d = ST_STABLE;
          else if (cnt_q == TMO_LAST) fail    = 1'b1;
        end
        ST_STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!locked_s) begin
            fail = 1'b1;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d     = ST_RESET;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAULT: ;
        default: state_d = ST_RESET;
      endcase
      // The last permitted attempt failing parks the PLL in reset for good.
      if (fail) begin
        if (retry_q == RTY_MAX) begin
          state_d = ST_FAULT;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RESET;
        end
      end
    end
    if (soft_restart || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retry_q    <= '0;
      sync_q     <= '0;
      pll_areset <= 1'b1;
      clk_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pll_locked};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_areset <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      clk_ready  <= (state_d == ST_RUN);
      lock_lost  <= lock_lost_d;
      fault      <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed bring-up/retry/fault scenarios with literal
// expectations, then randomized lock behaviour checked against a phase model.
module tb_pll_lock_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_areset, clk_ready, lock_lost, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  pll_lock_ctrl #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(16), .RTY_W(2)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_restart(soft_restart),
    .pll_areset(pll_areset), .clk_ready(clk_ready), .lock_lost(lock_lost),
    .fault(fault), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- checker ----------------
  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Phase plus cycles spent in it; lock seen by the controller is the input
  // as sampled two edges earlier (zeroed by rst).
  int m_phase = P_RESET;
  int m_age   = 0;
  int m_retry = 0;
  bit m_lost  = 1'b0;
  bit hist[$] = '{1'b0, 1'b0};

  function automatic void enter(int p);
    m_phase = p;
    m_age   = 0;
  endfunction

  function automatic void attempt_failed();
    if (m_retry == MR) enter(P_FAULT);
    else begin
      m_retry++;
      enter(P_RESET);
    end
  endfunction

  always @(posedge clk) begin
    bit ls;
    ls = hist[1];
    m_lost = 1'b0;
    if (rst || soft_restart) begin
      enter(P_RESET);
      m_retry = 0;
    end else begin
      m_age++;
      case (m_phase)
        P_RESET:  if (m_age == RC) enter(P_WAIT);
        P_WAIT:   if (ls) enter(P_STABLE);
                  else if (m_age == LT) attempt_failed();
        P_STABLE: if (!ls) attempt_failed();
                  else if (m_age == SC) begin enter(P_RUN); m_retry = 0; end
        P_RUN:    if (!ls) begin m_lost = 1'b1; enter(P_RESET); end
        default: ;
      endcase
    end
    if (rst) hist = '{1'b0, 1'b0};
    else begin
      hist.push_front(pll_locked);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    chk("pll_areset", int'(pll_areset), int'(m_phase == P_RESET || m_phase == P_FAULT));
    chk("clk_ready",  int'(clk_ready),  int'(m_phase == P_RUN));
    chk("fault",      int'(fault),      int'(m_phase == P_FAULT));
    chk("lock_lost",  int'(lock_lost),  int'(m_lost));
    chk("retry_cnt",  int'(retry_cnt),  m_retry);
    chk("state_dbg",  int'(state_dbg),  m_phase);
  end

  // ---------------- driver ----------------
  task automatic run(int n, bit r, bit s, bit l);
    for (int i = 0; i < n; i++) begin
      rst = r;
      soft_restart = s;
      pll_locked = l;
      @(negedge clk);
    end
  endtask

  initial begin
    // reset state
    run(3, 1, 0, 0);
    chk("rst_areset", int'(pll_areset), 1);
    chk("rst_ready", int'(clk_ready), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_lost", int'(lock_lost), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_state", int'(state_dbg), 0);

    // nominal bring-up: areset 4 cycles, lock 3 cycles later, ready 11 after lock
    run(3, 0, 0, 0);
    chk("nom_areset_hi", int'(pll_areset), 1);
    run(1, 0, 0, 0);
    chk("nom_areset_lo", int'(pll_areset), 0);
    chk("nom_wait", int'(state_dbg), 1);
    run(2, 0, 0, 0);
    run(10, 0, 0, 1);
    chk("nom_ready_early", int'(clk_ready), 0);
    chk("nom_stable", int'(state_dbg), 2);
    run(1, 0, 0, 1);
    chk("nom_ready", int'(clk_ready), 1);
    chk("nom_run", int'(state_dbg), 3);
    chk("nom_retry", int'(retry_cnt), 0);

    // lock loss in RUN
    run(2, 0, 0, 1);
    run(2, 0, 0, 0);
    chk("loss_ready_hold", int'(clk_ready), 1);
    chk("loss_lost_early", int'(lock_lost), 0);
    run(1, 0, 0, 0);
    chk("loss_pulse", int'(lock_lost), 1);
    chk("loss_ready_drop", int'(clk_ready), 0);
    chk("loss_areset", int'(pll_areset), 1);
    run(1, 0, 0, 0);
    chk("loss_pulse_end", int'(lock_lost), 0);
    run(2, 0, 0, 0);
    chk("loss_areset_hi", int'(pll_areset), 1);
    run(1, 0, 0, 0);
    chk("loss_areset_lo", int'(pll_areset), 0);
    chk("loss_retry", int'(retry_cnt), 0);

    // timeout retries leading to FAULT
    run(19, 0, 0, 0);
    chk("to1_wait", int'(state_dbg), 1);
    run(1, 0, 0, 0);
    chk("to1_reset", int'(state_dbg), 0);
    chk("to1_retry", int'(retry_cnt), 1);
    run(23, 0, 0, 0);
    run(1, 0, 0, 0);
    chk("to2_retry", int'(retry_cnt), 2);
    chk("to2_areset", int'(pll_areset), 1);
    run(23, 0, 0, 0);
    chk("to3_wait", int'(state_dbg), 1);
    run(1, 0, 0, 0);
    chk("to3_fault_state", int'(state_dbg), 4);
    chk("to3_fault", int'(fault), 1);
    chk("to3_retry", int'(retry_cnt), 2);
    run(10, 0, 0, 1);
    chk("fault_sticky", int'(state_dbg), 4);
    chk("fault_areset", int'(pll_areset), 1);

    // FAULT recovery via soft_restart
    run(1, 0, 1, 1);
    chk("rec_fault_clr", int'(fault), 0);
    chk("rec_retry", int'(retry_cnt), 0);
    run(3, 0, 0, 1);
    chk("rec_areset", int'(pll_areset), 1);
    run(1, 0, 0, 1);
    chk("rec_wait", int'(state_dbg), 1);
    run(1, 0, 0, 1);
    chk("rec_stable", int'(state_dbg), 2);
    run(7, 0, 0, 1);
    chk("rec_ready_early", int'(clk_ready), 0);
    run(1, 0, 0, 1);
    chk("rec_ready", int'(clk_ready), 1);

    // soft_restart in RUN, then a glitch during qualification
    run(1, 0, 1, 0);
    chk("soft_no_lost", int'(lock_lost), 0);
    chk("soft_ready_clr", int'(clk_ready), 0);
    run(4, 0, 0, 0);
    chk("gl_wait", int'(state_dbg), 1);
    run(5, 0, 0, 1);
    run(1, 0, 0, 0);
    run(1, 0, 0, 1);
    chk("gl_stable", int'(state_dbg), 2);
    run(1, 0, 0, 1);
    chk("gl_reset", int'(state_dbg), 0);
    chk("gl_retry", int'(retry_cnt), 1);
    run(12, 0, 0, 1);
    chk("gl_ready_early", int'(clk_ready), 0);
    run(1, 0, 0, 1);
    chk("gl_ready", int'(clk_ready), 1);
    chk("gl_retry_clr", int'(retry_cnt), 0);

    // rst together with soft_restart during STABLE (cnt=5)
    run(1, 0, 1, 1);
    run(4, 0, 0, 1);
    run(1, 0, 0, 1);
    run(5, 0, 0, 1);
    chk("mid_stable", int'(state_dbg), 2);
    run(1, 1, 1, 1);
    chk("mid_state", int'(state_dbg), 0);
    chk("mid_areset", int'(pll_areset), 1);
    run(4, 0, 0, 1);
    chk("mid_wait", int'(state_dbg), 1);
    run(1, 0, 0, 1);
    run(7, 0, 0, 1);
    chk("mid_ready_early", int'(clk_ready), 0);
    run(1, 0, 0, 1);
    chk("mid_ready", int'(clk_ready), 1);

    // randomized lock behaviour with occasional soft_restart / rst
    for (int blk = 0; blk < 160; blk++) begin
      int len;
      bit lv;
      len = $urandom_range(1, 60);
      lv  = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < len; i++) begin
        run(1, ($urandom_range(0, 499) == 0), ($urandom_range(0, 149) == 0), lv);
      end
    end
    run(2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
